contador_resp: RTL and testbench
================================

CONTADOR_RESP -- requirements
Module: contador_resp

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-003 SHALL have ports pop4, pop5, pop6, pop7, input, 1 bit each: pop strobes of output FIFOs 4..7.
REQ-004 SHALL have ports empty4, empty5, empty6, empty7, input, 1 bit each: empty flags of output FIFOs 4..7.
REQ-005 SHALL have port IDLE, input, 1 bit: system FSM reports idle; requests are accepted only while high.
REQ-006 SHALL have port req, input, 1 bit: count-read request strobe.
REQ-007 SHALL have port idx, input, 2 bits: FIFO select; 0..3 maps to FIFO 4..7.
REQ-008 SHALL have port valid_contador, output, 1 bit: contador_out is valid this cycle.
REQ-009 SHALL have port contador_out, output, 5 bits: count of words popped from the selected FIFO.

Function
REQ-010 SHALL keep four internal 5-bit counters cnt[0..3], one per FIFO 4..7.
REQ-011 SHALL increment cnt[i] at a rising edge when pop(4+i)=1 and empty(4+i)=0 at that edge; pop on an empty FIFO SHALL NOT count.
REQ-012 SHALL saturate each counter at 31; further valid pops leave it at 31; no wrap to 0.
REQ-013 SHALL update all four counters independently, and simultaneously when required, in every FSM state.
REQ-014 SHALL implement FSM states COUNTING, READY, RESPOND.
REQ-015 COUNTING: valid_contador=0; req ignored; next state READY when IDLE=1, else COUNTING.
REQ-016 READY: when req=1 and IDLE=1 at edge k, SHALL register contador_out <= cnt[idx] and valid_contador <= 1, and move to RESPOND; when IDLE=0, SHALL move to COUNTING; otherwise SHALL stay in READY.
REQ-017 The value captured at edge k SHALL be cnt[idx] as it was before edge k; a pop counted at edge k SHALL NOT appear in that response.
REQ-018 Latency: valid_contador SHALL be high exactly one cycle, the cycle following edge k.
REQ-019 RESPOND: SHALL ignore req; at the next edge SHALL drop valid_contador and go to READY if IDLE=1, else COUNTING. Back-to-back responses SHALL therefore occur at most every 2 cycles.
REQ-020 contador_out SHALL hold its last captured value while valid_contador=0.
REQ-021 IDLE falling while in RESPOND SHALL NOT truncate the one-cycle valid pulse.

Reset
REQ-022 When reset=0 at a rising edge: all cnt = 0, contador_out = 0, valid_contador = 0, state = COUNTING; pops at that edge SHALL NOT count.
REQ-023 Reset asserted mid-response SHALL clear valid_contador at that edge; no pending response survives reset.

Configuration
REQ-024 Macro CONTADOR_CLEAR_ON_READ_EN: when defined, the read at edge k SHALL also clear cnt[idx]. A valid pop on that FIFO at the same edge SHALL leave cnt[idx]=1, otherwise 0. When undefined, reads SHALL NOT modify counters.

Verification
REQ-025 Reset low for 2 cycles, then IDLE=1, req=1, idx=2 -> one-cycle valid_contador pulse with contador_out=0.
REQ-026 pop4=1, empty4=0 for 6 cycles; then IDLE=1, req with idx=0 -> contador_out=6 with a single valid pulse; pop5=1 with empty5=1 for 4 cycles -> read idx=1 returns 0.
REQ-027 pop6 valid for 40 cycles -> read idx=2 returns 31 (saturated).
REQ-028 req held high for 4 cycles in READY -> valid pulses in cycles 2 and 4 only; req while IDLE=0 -> no pulse; pop at the request edge excluded (5 pops, 6th pop on the read edge -> returns 5, a later read returns 6).
REQ-029 With CONTADOR_CLEAR_ON_READ_EN: 3 pops on FIFO7, read idx=3 -> 3, immediate re-read -> 0; read coinciding with a pop -> next read returns 1.
REQ-030 reset=0 during RESPOND -> valid_contador=0 and contador_out=0 from the next cycle, and all counters read 0 afterwards.

Source files
------------

// File: rtl/contador_resp.sv
// Pop counter for output FIFOs 4..7 with a one-cycle count read-back handshake.
// Optional build macro CONTADOR_CLEAR_ON_READ_EN: a read also clears the counter it returns.
module contador_resp (
  input  logic       clk,
  input  logic       reset,
  input  logic       pop4,
  input  logic       pop5,
  input  logic       pop6,
  input  logic       pop7,
  input  logic       empty4,
  input  logic       empty5,
  input  logic       empty6,
  input  logic       empty7,
  input  logic       IDLE,
  input  logic       req,
  input  logic [1:0] idx,
  output logic       valid_contador,
  output logic [4:0] contador_out
);

  localparam logic [1:0] COUNTING = 2'd0;
  localparam logic [1:0] READY    = 2'd1;
  localparam logic [1:0] RESPOND  = 2'd2;

  localparam logic [4:0] CNT_MAX = 5'd31;

  logic [1:0] state;
  logic [4:0] cnt      [4];
  logic [4:0] cnt_next [4];
  logic [3:0] pop_ok;
  logic       read;

  // A pop on an empty FIFO moved no data, so it is not counted.
  assign pop_ok = {pop7 & ~empty7, pop6 & ~empty6, pop5 & ~empty5, pop4 & ~empty4};
  assign read   = (state == READY) && IDLE && req;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = cnt[i];
      if (pop_ok[i] && (cnt[i] != CNT_MAX)) cnt_next[i] = cnt[i] + 5'd1;
`ifdef CONTADOR_CLEAR_ON_READ_EN
      // The read returns the pre-edge value; a pop on the same edge starts the new count.
      if (read && (idx == 2'(i))) cnt_next[i] = {4'd0, pop_ok[i]};
`endif
    end
  end

  // NOTE: the counters are a handful of flops, not a memory, so they are reset like any other state.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset) cnt[i] <= '0;
      else        cnt[i] <= cnt_next[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= COUNTING;
      valid_contador <= 1'b0;
      contador_out   <= '0;
    end else begin
      valid_contador <= read;
      if (read) contador_out <= cnt[idx];
      case (state)
        READY:   state <= read ? RESPOND : (IDLE ? READY : COUNTING);
        // COUNTING and RESPOND both fall back on IDLE alone; the pulse is never cut short.
        default: state <= IDLE ? READY : COUNTING;
      endcase
    end
  end

endmodule

// File: tb/tb_contador_resp.sv
// Self-checking bench for contador_resp: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the pop counters and read handshake.
module tb_contador_resp;

  bit         clk = 1'b0;
  logic       reset;
  logic       pop4, pop5, pop6, pop7;
  logic       empty4, empty5, empty6, empty7;
  logic       IDLE;
  logic       req;
  logic [1:0] idx;
  logic       valid_contador;
  logic [4:0] contador_out;

  int checks   = 0;
  int failures = 0;

  contador_resp dut (
    .clk            (clk),
    .reset          (reset),
    .pop4           (pop4),
    .pop5           (pop5),
    .pop6           (pop6),
    .pop7           (pop7),
    .empty4         (empty4),
    .empty5         (empty5),
    .empty6         (empty6),
    .empty7         (empty7),
    .IDLE           (IDLE),
    .req            (req),
    .idx            (idx),
    .valid_contador (valid_contador),
    .contador_out   (contador_out)
  );

  always #5 clk = ~clk;

`ifdef CONTADOR_CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pop tallies saturating at 31, and a "can accept a read" flag.
  int  m_cnt [4];
  int  m_out;
  bit  m_valid;
  bit  m_armed;
  bit  model_ok = 1'b0;

  always @(posedge clk) begin
    bit       fire;
    bit [3:0] taken;
    int       sel;
    taken = {pop7 & ~empty7, pop6 & ~empty6, pop5 & ~empty5, pop4 & ~empty4};
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_out    = 0;
      m_valid  = 1'b0;
      m_armed  = 1'b0;
      model_ok = 1'b1;
    end else begin
      sel     = int'(idx);
      fire    = m_armed && IDLE && req;
      m_valid = fire;
      if (fire) m_out = m_cnt[sel];
      for (int i = 0; i < 4; i++) begin
        if (CLR && fire && sel == i) m_cnt[i] = taken[i] ? 1 : 0;
        else if (taken[i])          m_cnt[i] = (m_cnt[i] >= 31) ? 31 : m_cnt[i] + 1;
      end
      // A read can be accepted at an edge only if IDLE held at the previous edge and no read fired there.
      m_armed = IDLE && !fire;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("valid_contador", valid_contador, m_valid);
      check("contador_out", contador_out, m_out);
    end
  end

  task automatic drive_pops(input logic [3:0] pops, input logic [3:0] empties, input int n);
    {pop7, pop6, pop5, pop4}         = pops;
    {empty7, empty6, empty5, empty4} = empties;
    repeat (n) @(negedge clk);
    {pop7, pop6, pop5, pop4}         = 4'b0000;
    {empty7, empty6, empty5, empty4} = 4'b0000;
  endtask

  task automatic do_read(input logic [1:0] sel, input logic [4:0] exp, input string name);
    bit         seen;
    logic [4:0] got;
    seen = 1'b0;
    got  = '0;
    IDLE = 1'b1;
    idx  = sel;
    req  = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (valid_contador === 1'b1) begin
        seen = 1'b1;
        got  = contador_out;
      end
    end
    req = 1'b0;
    check({name, "_seen"}, 32'(seen), 32'd1);
    check(name, 32'(got), 32'(exp));
    @(negedge clk);
    check({name, "_single"}, 32'(valid_contador), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] pat;
    int         npulse;
    bit         seen;

    reset = 1'b0;
    IDLE  = 1'b0;
    req   = 1'b0;
    idx   = 2'd0;
    {pop7, pop6, pop5, pop4}         = 4'b0000;
    {empty7, empty6, empty5, empty4} = 4'b0000;

    // Two reset cycles, then a read of an untouched counter.
    repeat (2) @(negedge clk);
    check("reset_valid", 32'(valid_contador), 32'd0);
    check("reset_out", 32'(contador_out), 32'd0);
    reset = 1'b1;
    do_read(2'd2, 5'd0, "read_after_reset");

    // Six valid pops on FIFO4; pops on an empty FIFO5 are not counted.
    IDLE = 1'b0;
    drive_pops(4'b0001, 4'b0000, 6);
    do_read(2'd0, 5'd6, "fifo4_six");
    drive_pops(4'b0010, 4'b0010, 4);
    do_read(2'd1, 5'd0, "fifo5_empty_pops");

    // Saturation at 31.
    drive_pops(4'b0100, 4'b0000, 40);
    do_read(2'd2, 5'd31, "fifo6_saturated");

    // req held four cycles in READY: pulses in the 1st and 3rd observed cycles only.
    req = 1'b1;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat[3-k] = valid_contador;
    end
    req = 1'b0;
    check("held_req_pattern", 32'(pat), 32'b1010);
    @(negedge clk);

    // Requests while not idle get no response.
    IDLE   = 1'b0;
    req    = 1'b1;
    npulse = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (valid_contador === 1'b1) npulse++;
    end
    req = 1'b0;
    check("no_pulse_when_busy", 32'(npulse), 32'd0);

    // A pop on the read edge is excluded from that response.
    pulse_reset();
    IDLE = 1'b1;
    drive_pops(4'b1000, 4'b0000, 5);
    pop7 = 1'b1;
    req  = 1'b1;
    idx  = 2'd3;
    @(negedge clk);
    pop7 = 1'b0;
    req  = 1'b0;
    check("pop_on_read_valid", 32'(valid_contador), 32'd1);
    check("pop_on_read_out", 32'(contador_out), 32'd5);
    @(negedge clk);
    do_read(2'd3, CLR ? 5'd1 : 5'd6, "pop_on_read_later");

    // Three pops then two back-to-back reads (second read sees the clear when enabled).
    pulse_reset();
    drive_pops(4'b1000, 4'b0000, 3);
    do_read(2'd3, 5'd3, "fifo7_first_read");
    do_read(2'd3, CLR ? 5'd0 : 5'd3, "fifo7_reread");

    // Reset during the response cycle kills the pulse and clears everything.
    IDLE = 1'b0;
    drive_pops(4'b1111, 4'b0000, 3);
    IDLE = 1'b1;
    idx  = 2'd0;
    req  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (valid_contador === 1'b1) seen = 1'b1;
    end
    check("respond_seen", 32'(seen), 32'd1);
    check("respond_out", 32'(contador_out), 32'd3);
    req   = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_respond_valid", 32'(valid_contador), 32'd0);
    check("reset_in_respond_out", 32'(contador_out), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) do_read(2'(i), 5'd0, "cleared_by_reset");

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 199) != 0);
      IDLE   = ($urandom_range(0, 3) != 0);
      req    = 1'($urandom_range(0, 1));
      idx    = 2'($urandom_range(0, 3));
      {pop7, pop6, pop5, pop4}         = 4'($urandom);
      {empty7, empty6, empty5, empty4} = 4'($urandom) & 4'($urandom);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
